// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port async SRAM controller with programmable read/write wait states
module sram_ctrl #(
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        rnw,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        ready,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [15:0] sram_addr,
   inout  wire  [7:0]  sram_data,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACT,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
   } state_t;

   // Counters are preloaded with WAIT-1 so the terminal count lands on the last strobe cycle.
   localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
   localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        drive_q, drive_d;
   logic        done_d;
   logic [7:0]  rdata_d;
   logic [15:0] addr_d;
   logic        ce_d, oe_d, we_d;

   assign ready     = (state_q == IDLE);
   assign sram_data = drive_q ? wdata_q : 8'bz;

   // Next-state and next-pin values; every pin is registered so nothing from req reaches the SRAM combinationally.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      drive_d = drive_q;
      done_d  = 1'b0;
      rdata_d = rdata;
      addr_d  = sram_addr;
      ce_d    = sram_ce_n;
      oe_d    = sram_oe_n;
      we_d    = sram_we_n;
      case (state_q)
         IDLE: begin
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            we_d    = 1'b1;
            drive_d = 1'b0;
            if (req) begin
               addr_d = addr;
               ce_d   = 1'b0;
               if (rnw) begin
                  state_d = RD_ACT;
                  oe_d    = 1'b0;
                  cnt_d   = RD_CNT;
               end else begin
                  // Bus starts driving with oe_n high; the previous idle cycle already had oe_n high.
                  state_d = WR_SETUP;
                  wdata_d = wdata;
                  drive_d = 1'b1;
               end
            end
         end
         RD_ACT: begin
            if (cnt_q == 4'd0) begin
               rdata_d = sram_data;
               done_d  = 1'b1;
               ce_d    = 1'b1;
               oe_d    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WR_SETUP: begin
            we_d    = 1'b0;
            cnt_d   = WR_CNT;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_q == 4'd0) begin
               we_d    = 1'b1;
               state_d = WR_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WR_HOLD: begin
            ce_d    = 1'b1;
            drive_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            we_d    = 1'b1;
            drive_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and registered SRAM pins; reset aborts any access in flight without a done pulse.
   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         wdata_q   <= 8'd0;
         drive_q   <= 1'b0;
         done      <= 1'b0;
         rdata     <= 8'd0;
         sram_addr <= 16'd0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wdata_q   <= wdata_d;
         drive_q   <= drive_d;
         done      <= done_d;
         rdata     <= rdata_d;
         sram_addr <= addr_d;
         sram_ce_n <= ce_d;
         sram_oe_n <= oe_d;
         sram_we_n <= we_d;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with behavioural SRAM and reference memory
module tb_sram_ctrl;
   localparam int RW = 2;
   localparam int WW = 2;

   logic        fclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rnw = 1'b0;
   logic [15:0] addr = 16'd0;
   logic [7:0]  wdata = 8'd0;
   logic        req0 = 1'b0, req1 = 1'b0;

   logic        ready0, done0, ce0, oe0, we0;
   logic [7:0]  rdata0;
   logic [15:0] sa0;
   wire  [7:0]  sd0;
   logic        ready1, done1, ce1, oe1, we1;
   logic [7:0]  rdata1;
   logic [15:0] sa1;
   wire  [7:0]  sd1;

   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem1 [0:65535];
   logic [7:0]  ref_mem [0:65535];

   int n_checks = 0;
   int n_fail = 0;
   int ce_starts = 0;
   logic rst_seen = 1'b0;

   sram_ctrl #(.RD_WAIT(RW), .WR_WAIT(WW)) dut0 (
      .fclk(fclk), .rst_n(rst_n), .req(req0), .rnw(rnw), .addr(addr), .wdata(wdata),
      .ready(ready0), .done(done0), .rdata(rdata0), .sram_addr(sa0), .sram_data(sd0),
      .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0));

   sram_ctrl #(.RD_WAIT(1), .WR_WAIT(1)) dut1 (
      .fclk(fclk), .rst_n(rst_n), .req(req1), .rnw(rnw), .addr(addr), .wdata(wdata),
      .ready(ready1), .done(done1), .rdata(rdata1), .sram_addr(sa1), .sram_data(sd1),
      .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

   // An undriven bus floats to 8'hFF; write data in this bench is never 8'hFF, so FF means "not driven".
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (sd0[i]);
      pullup (sd1[i]);
   end

   assign sd0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 8'bz;
   assign sd1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 8'bz;

   always #5 fclk = ~fclk;

   // SRAM array write while ce_n and we_n are low; also remember reset level per edge.
   always @(posedge fclk) begin
      if (!ce0 && !we0) mem0[sa0] <= sd0;
      if (!ce1 && !we1) mem1[sa1] <= sd1;
      rst_seen <= rst_n;
   end

   // Bus protocol monitor for dut0: contention, turnaround gaps, write setup/hold.
   logic prev_oe = 1'b1, prev_we = 1'b1, prev_ce = 1'b1, prev_drv = 1'b0, prev_rst = 1'b0;
   logic [15:0] prev_addr = 16'd0;
   logic [7:0]  prev_data = 8'd0;
   always @(negedge fclk) begin
      logic drv;
      logic [5:0] bad;
      drv = oe0 && (sd0 !== 8'hFF);
      if (rst_seen && prev_rst) begin
         bad = 6'd0;
         if (!oe0 && (sd0 !== mem0[sa0])) bad[0] = 1'b1;
         if (!oe0 && prev_oe && prev_drv) bad[1] = 1'b1;
         if (drv && !prev_oe) bad[2] = 1'b1;
         if (!we0 && ce0) bad[3] = 1'b1;
         if (!we0 && prev_we && (!prev_drv || prev_addr !== sa0 || prev_data !== sd0)) bad[4] = 1'b1;
         if (we0 && !prev_we && (!drv || prev_addr !== sa0 || prev_data !== sd0)) bad[5] = 1'b1;
         n_checks++;
         if (bad !== 6'd0) begin
            n_fail++;
            $display("FAIL bus_protocol t=%0t got violations=%b required=000000", $time, bad);
         end
      end
      if (!ce0 && prev_ce) ce_starts++;
      prev_oe = oe0; prev_we = we0; prev_ce = ce0; prev_drv = drv;
      prev_addr = sa0; prev_data = sd0; prev_rst = rst_seen;
   end

   // Issues one access starting at the current negedge (cycle 0) and returns at the negedge of the done cycle.
   task automatic access(input bit inst, input bit r, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd,
                         output logic [63:0] oe_low, output logic [63:0] we_low);
      rnw = r; addr = a; wdata = d;
      if (inst) req1 = 1'b1; else req0 = 1'b1;
      @(negedge fclk);
      if (inst) req1 = 1'b0; else req0 = 1'b0;
      lat = 1; oe_low = 64'd0; we_low = 64'd0;
      while (1) begin
         oe_low[lat] = inst ? !oe1 : !oe0;
         we_low[lat] = inst ? !we1 : !we0;
         if ((inst ? done1 : done0) || lat >= 63) break;
         @(negedge fclk);
         lat++;
      end
      rd = inst ? rdata1 : rdata0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge fclk);
      n_checks++;
      if ({ready0, done0, ce0, oe0, we0} !== 5'b10111) begin
         n_fail++; $display("FAIL reset_ctrl got %b required 10111", {ready0, done0, ce0, oe0, we0});
      end
      n_checks++;
      if (rdata0 !== 8'h00 || sa0 !== 16'h0000) begin
         n_fail++; $display("FAIL reset_regs got rdata=%h addr=%h required 00/0000", rdata0, sa0);
      end
      n_checks++;
      if (sd0 !== 8'hFF) begin
         n_fail++; $display("FAIL reset_bus_z got %h required floating FF", sd0);
      end
      n_checks++;
      if ({ready1, done1, ce1, oe1, we1, rdata1} !== {5'b10111, 8'h00}) begin
         n_fail++; $display("FAIL reset_dut1 got %b required 1011100000000", {ready1, done1, ce1, oe1, we1, rdata1});
      end
      rst_n = 1'b1;
      @(negedge fclk);
   endtask

   task automatic test_write_read;
      int lat; logic [7:0] rd; logic [63:0] ol, wl;
      access(0, 0, 16'h1234, 8'hA5, lat, rd, ol, wl);
      ref_mem[16'h1234] = 8'hA5;
      n_checks++;
      if (lat !== WW + 3) begin n_fail++; $display("FAIL wr_latency got %0d required %0d", lat, WW + 3); end
      n_checks++;
      if (wl !== (((64'd1 << WW) - 1) << 2)) begin n_fail++; $display("FAIL wr_we_window got %h required %h", wl, ((64'd1 << WW) - 1) << 2); end
      @(negedge fclk);
      access(0, 1, 16'h1234, 8'h00, lat, rd, ol, wl);
      n_checks++;
      if (lat !== RW + 1) begin n_fail++; $display("FAIL rd_latency got %0d required %0d", lat, RW + 1); end
      n_checks++;
      if (ol !== (((64'd1 << RW) - 1) << 1)) begin n_fail++; $display("FAIL rd_oe_window got %h required %h", ol, ((64'd1 << RW) - 1) << 1); end
      n_checks++;
      if (rd !== ref_mem[16'h1234]) begin n_fail++; $display("FAIL rd_data got %h required %h", rd, ref_mem[16'h1234]); end
      @(negedge fclk);
      access(0, 0, 16'h1234, 8'h3C, lat, rd, ol, wl);
      ref_mem[16'h1234] = 8'h3C;
      n_checks++;
      if (rd !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold got %h required a5", rd); end
      @(negedge fclk);
   endtask

   task automatic test_back_to_back;
      int lat; logic [7:0] rd; logic [63:0] ol, wl;
      access(0, 0, 16'hFFFF, 8'h5A, lat, rd, ol, wl);
      ref_mem[16'hFFFF] = 8'h5A;
      access(0, 1, 16'hFFFF, 8'h00, lat, rd, ol, wl);
      n_checks++;
      if (lat !== RW + 1 || rd !== ref_mem[16'hFFFF]) begin
         n_fail++; $display("FAIL b2b_read got lat=%0d data=%h required %0d/%h", lat, rd, RW + 1, ref_mem[16'hFFFF]);
      end
      access(0, 0, 16'h0000, 8'hC3, lat, rd, ol, wl);
      ref_mem[16'h0000] = 8'hC3;
      n_checks++;
      if (lat !== WW + 3) begin n_fail++; $display("FAIL b2b_write_latency got %0d required %0d", lat, WW + 3); end
      @(negedge fclk);
      n_checks++;
      if (mem0[16'h0000] !== ref_mem[16'h0000] || mem0[16'hFFFF] !== ref_mem[16'hFFFF]) begin
         n_fail++; $display("FAIL b2b_mem got %h/%h required %h/%h", mem0[16'h0000], mem0[16'hFFFF], ref_mem[16'h0000], ref_mem[16'hFFFF]);
      end
   endtask

   task automatic test_held_req;
      int c0, n, n2;
      c0 = ce_starts;
      rnw = 1'b0; addr = 16'h0100; wdata = 8'h11; req0 = 1'b1;
      @(negedge fclk);
      n = 1;
      while (!done0 && n < 64) begin
         addr = 16'h8000 | 16'($urandom);
         wdata = 8'($urandom_range(0, 254));
         @(negedge fclk);
         n++;
      end
      addr = 16'h0200; wdata = 8'h22;
      @(negedge fclk);
      req0 = 1'b0;
      n2 = 1;
      while (!done0 && n2 < 64) begin @(negedge fclk); n2++; end
      ref_mem[16'h0100] = 8'h11; ref_mem[16'h0200] = 8'h22;
      n_checks++;
      if (n !== WW + 3 || n2 !== WW + 3) begin
         n_fail++; $display("FAIL held_req_latency got %0d/%0d required %0d/%0d", n, n2, WW + 3, WW + 3);
      end
      @(negedge fclk);
      n_checks++;
      if (ce_starts - c0 !== 2) begin n_fail++; $display("FAIL held_req_count got %0d accesses required 2", ce_starts - c0); end
      n_checks++;
      if (mem0[16'h0100] !== ref_mem[16'h0100] || mem0[16'h0200] !== ref_mem[16'h0200]) begin
         n_fail++; $display("FAIL held_req_data got %h/%h required 11/22", mem0[16'h0100], mem0[16'h0200]);
      end
   endtask

   task automatic test_reset_mid_write;
      logic saw_done;
      rnw = 1'b0; addr = 16'h0300; wdata = 8'h77; req0 = 1'b1;
      @(negedge fclk);
      req0 = 1'b0;
      @(negedge fclk);
      @(negedge fclk);
      n_checks++;
      if (we0 !== 1'b0) begin n_fail++; $display("FAIL abort_precond got we_n=%b required 0", we0); end
      rst_n = 1'b0;
      @(negedge fclk);
      n_checks++;
      if ({we0, ce0, oe0, done0, ready0} !== 5'b11101 || sd0 !== 8'hFF) begin
         n_fail++; $display("FAIL abort_state got we/ce/oe/done/ready=%b bus=%h required 11101/FF", {we0, ce0, oe0, done0, ready0}, sd0);
      end
      @(negedge fclk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (4) begin @(negedge fclk); if (done0) saw_done = 1'b1; end
      n_checks++;
      if (saw_done !== 1'b0 || ready0 !== 1'b1) begin
         n_fail++; $display("FAIL abort_no_done got done_seen=%b ready=%b required 0/1", saw_done, ready0);
      end
   endtask

   task automatic test_random;
      logic [15:0] pool [6];
      int lat; logic [7:0] rd, d; logic [63:0] ol, wl; bit r; int k, errs;
      for (int i = 0; i < 6; i++) begin
         pool[i] = 16'($urandom);
         d = 8'($urandom_range(0, 254));
         access(0, 0, pool[i], d, lat, rd, ol, wl);
         ref_mem[pool[i]] = d;
      end
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) @(negedge fclk);
         r = 1'($urandom_range(0, 1));
         k = $urandom_range(0, 5);
         d = 8'($urandom_range(0, 254));
         access(0, r, pool[k], d, lat, rd, ol, wl);
         n_checks++;
         if (r) begin
            if (lat !== RW + 1 || rd !== ref_mem[pool[k]]) begin
               n_fail++; $display("FAIL rand_read[%0d] got lat=%0d data=%h required %0d/%h", i, lat, rd, RW + 1, ref_mem[pool[k]]);
            end
         end else begin
            ref_mem[pool[k]] = d;
            if (lat !== WW + 3) begin
               n_fail++; $display("FAIL rand_write[%0d] got lat=%0d required %0d", i, lat, WW + 3);
            end
         end
      end
      @(negedge fclk);
   endtask

   task automatic test_short_waits;
      int lat; logic [7:0] rd; logic [63:0] ol, wl;
      access(1, 0, 16'hBEEF, 8'h69, lat, rd, ol, wl);
      n_checks++;
      if (lat !== 4 || wl !== 64'h4) begin n_fail++; $display("FAIL short_write got lat=%0d we=%h required 4/4", lat, wl); end
      access(1, 1, 16'hBEEF, 8'h00, lat, rd, ol, wl);
      n_checks++;
      if (lat !== 2 || ol !== 64'h2 || rd !== 8'h69) begin
         n_fail++; $display("FAIL short_read got lat=%0d oe=%h data=%h required 2/2/69", lat, ol, rd);
      end
      access(1, 0, 16'h0001, 8'h96, lat, rd, ol, wl);
      access(1, 1, 16'h0001, 8'h00, lat, rd, ol, wl);
      n_checks++;
      if (lat !== 2 || rd !== 8'h96) begin n_fail++; $display("FAIL short_b2b got lat=%0d data=%h required 2/96", lat, rd); end
      @(negedge fclk);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_held_req();
      test_reset_mid_write();
      test_random();
      test_short_waits();
      repeat (2) @(negedge fclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
